// File: rtl/pico9_uart.sv
// pico9_uart: byte-oriented UART peripheral on the pico9 I/O port bus.
//
// Transmit and receive bytes are buffered in DEPTH-entry FIFOs. Data, status,
// control and a 16-bit baud divisor are exposed as 9-bit I/O registers.
// Reads with side effects happen only under iord; writes only under iowr.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   port[2:0]    I/O register select (CPU port)
//   iord         read strobe; pops RX data (port 0) or clears sticky bits (port 1)
//   iowr         write strobe
//   wdata[8:0]   write data (CPU data_out)
//   rdata[8:0]   combinational read data (CPU data_in)
//   rxd          asynchronous serial input, idle high
//   txd          serial output, idle high

// Byte FIFO with count. A flush beats a same-cycle push or pop; a push into a
// full FIFO is accepted only when a real pop happens in the same cycle.
module pico9_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign drop    = push && !flush && full && !do_pop;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module pico9_uart #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] port,
    input  logic       iord,
    input  logic       iowr,
    input  logic [8:0] wdata,
    output logic [8:0] rdata,
    input  logic       rxd,
    output logic       txd
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

    // Register file
    logic [15:0] divisor;
    logic [15:0] div_eff;
    logic        loopback;
    logic        rx_overrun;
    logic        frame_err;
    logic        tx_overflow;

    // Bus decode
    logic wr_data, wr_ctl, wr_div_lo, wr_div_hi, rd_data, rd_status;
    logic rx_flush, tx_flush;

    // FIFOs
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_drop, rx_drop;
    logic          tx_empty, tx_full, rx_nonempty;

    // TX path
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit_idx;
    logic        tx_bit_end, tx_pop, tx_idle;

    // RX path
    rx_state_t   rx_state, rx_next;
    logic        rxd_meta, rxd_sync, rx_line;
    logic [15:0] rx_cnt, rx_div, rx_half_m1;
    logic [7:0]  rx_shift, rx_byte;
    logic [2:0]  rx_bit_idx;
    logic        rx_bit_end, rx_half_end, rx_push, rx_frame_err;

    // Divisors below 3 would leave too few clocks for mid-bit sampling.
    assign div_eff = (divisor < 16'd3) ? 16'd3 : divisor;

    assign wr_data   = iowr && (port == 3'd0);
    assign wr_ctl    = iowr && (port == 3'd1);
    assign wr_div_lo = iowr && (port == 3'd2);
    assign wr_div_hi = iowr && (port == 3'd3);
    assign rd_data   = iord && (port == 3'd0);
    assign rd_status = iord && (port == 3'd1);
    assign rx_flush  = wr_ctl && wdata[0];
    assign tx_flush  = wr_ctl && wdata[1];

    pico9_uart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (wdata[7:0]),
        .dout  (tx_head),
        .count (tx_count),
        .drop  (tx_drop)
    );

    pico9_uart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rd_data),
        .flush (rx_flush),
        .din   (rx_byte),
        .dout  (rx_head),
        .count (rx_count),
        .drop  (rx_drop)
    );

    assign tx_empty    = (tx_count == '0);
    assign tx_full     = (tx_count == CW'(DEPTH));
    assign rx_nonempty = (rx_count != '0);
    assign tx_idle     = (tx_state == TX_IDLE) && tx_empty;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor     <= DIV_RESET;
            loopback    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_div_lo) divisor[8:0]  <= wdata;
            if (wr_div_hi) divisor[15:9] <= wdata[6:0];
            if (wr_ctl)    loopback      <= wdata[2];
            // A new event in the same cycle as a clear stays visible.
            rx_overrun  <= (rx_overrun  && !rd_status) || rx_drop;
            frame_err   <= (frame_err   && !rd_status) || rx_frame_err;
            tx_overflow <= (tx_overflow && !rd_status) || tx_drop;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statements can infer a latch.
    always_comb begin
        rdata = 9'd0;
        case (port)
            3'd0: rdata = {rx_nonempty, rx_nonempty ? rx_head : 8'd0};
            3'd1: rdata = {2'b00, loopback, tx_overflow, frame_err, rx_overrun,
                           tx_idle, tx_full, rx_nonempty};
            3'd2: rdata = divisor[8:0];
            3'd3: rdata = {2'b00, divisor[15:9]};
            default: rdata = 9'd0;
        endcase
    end

    // ---------------------------------------------------------------- TX FSM
    assign tx_bit_end = (tx_cnt == tx_div);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_idx == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // The bit period is latched at each bit boundary so a divisor write never
    // stretches or truncates the bit currently on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            txd        <= 1'b1;
            tx_cnt     <= 16'd0;
            tx_div     <= 16'd3;
            tx_shift   <= 8'd0;
            tx_bit_idx <= 3'd0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        txd      <= 1'b0;
                        tx_cnt   <= 16'd0;
                        tx_div   <= div_eff;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        txd        <= tx_shift[0];
                        tx_cnt     <= 16'd0;
                        tx_div     <= div_eff;
                        tx_bit_idx <= 3'd0;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= 16'd0;
                        tx_div <= div_eff;
                        if (tx_bit_idx == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            txd        <= tx_shift[1];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                            tx_bit_idx <= tx_bit_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    tx_cnt <= tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
                end
                default: txd <= 1'b1;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Loopback listens to the registered txd; it is already synchronous.
    assign rx_line     = loopback ? txd : rxd_sync;
    assign rx_bit_end  = (rx_cnt == rx_div);
    assign rx_half_end = (rx_cnt == rx_half_m1);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next      = rx_state;
        rx_frame_err = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_line) rx_next = RX_START;
            RX_START: if (rx_half_end) rx_next = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_next      = rx_line ? RX_IDLE : RX_WAITHI;
                    rx_frame_err = !rx_line;
                end
            end
            RX_WAITHI: if (rx_line) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt     <= 16'd0;
            rx_div     <= 16'd3;
            rx_half_m1 <= 16'd1;
            rx_shift   <= 8'd0;
            rx_byte    <= 8'd0;
            rx_bit_idx <= 3'd0;
            rx_push    <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_line) begin
                        rx_cnt     <= 16'd0;
                        rx_div     <= div_eff;
                        // ((div+1)>>1) - 1 == (div-1)>>1; div_eff >= 3 so no wrap.
                        rx_half_m1 <= (div_eff - 16'd1) >> 1;
                    end
                end
                RX_START: begin
                    if (rx_half_end) begin
                        rx_cnt     <= 16'd0;
                        rx_div     <= div_eff;
                        rx_bit_idx <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_shift   <= {rx_line, rx_shift[7:1]};
                        rx_bit_idx <= rx_bit_idx + 3'd1;
                        rx_cnt     <= 16'd0;
                        rx_div     <= div_eff;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= 16'd0;
                        if (rx_line) begin
                            rx_push <= 1'b1;
                            rx_byte <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_cnt <= 16'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_pico9_uart.sv
`timescale 1ns/1ps
// Self-checking bench for pico9_uart: register-map vector table, exact TX bit
// timing, randomized loopback frames decoded from txd, external RX frames with
// overrun/framing/glitch cases, TX overflow and flush, and reset mid-frame.
module tb_pico9_uart;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] port;
    logic       iord;
    logic       iowr;
    logic [8:0] wdata;
    logic [8:0] rdata;
    logic       rxd;
    logic       txd;

    int checks = 0;
    int errors = 0;

    pico9_uart #(.DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
        .clk   (clk),
        .reset (reset),
        .port  (port),
        .iord  (iord),
        .iowr  (iowr),
        .wdata (wdata),
        .rdata (rdata),
        .rxd   (rxd),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         is_wr;
        logic [2:0] port;
        logic [8:0] data;
        logic [8:0] exp;
        string      name;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] p, output logic [8:0] v);
        port = p;
        #1;
        v = rdata;
    endtask

    task automatic io_write(input logic [2:0] p, input logic [8:0] d);
        port  = p;
        wdata = d;
        iowr  = 1'b1;
        tick();
        iowr  = 1'b0;
    endtask

    task automatic io_read(input logic [2:0] p, input bit do_pop, output logic [8:0] v);
        port = p;
        #1;
        v    = rdata;
        iord = do_pop;
        tick();
        iord = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] d);
        io_write(3'd2, d[8:0]);
        io_write(3'd3, {2'b00, d[15:9]});
    endtask

    task automatic wait_tx_idle(input int budget, input string name);
        logic [8:0] s;
        int n = 0;
        peek(3'd1, s);
        while (!s[2] && n < budget) begin
            tick();
            peek(3'd1, s);
            n++;
        end
        check(name, {15'd0, s[2]}, 16'd1);
    endtask

    // Drive one frame on rxd: start, 8 data bits LSB first, stop bit value.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (p) tick();
        end
        rxd = 1'b1;
    endtask

    vec_t       vecs [17];
    logic [8:0] v;
    logic [7:0] q [$];

    initial begin
        reset = 1'b1; iord = 1'b0; iowr = 1'b0; port = 3'd0; wdata = 9'd0; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_txd", {15'd0, txd}, 16'd1);

        // ---------------------------------------------------- register map table
        vecs = '{
            '{1'b0, 3'd1, 9'h000, 9'h004, "rst_status"},
            '{1'b0, 3'd2, 9'h000, 9'h1B1, "rst_div_lo"},
            '{1'b0, 3'd3, 9'h000, 9'h000, "rst_div_hi"},
            '{1'b0, 3'd0, 9'h000, 9'h000, "rst_rx_data"},
            '{1'b0, 3'd5, 9'h000, 9'h000, "rst_port5"},
            '{1'b1, 3'd2, 9'h0AA, 9'h000, "wr_div_lo"},
            '{1'b0, 3'd2, 9'h000, 9'h0AA, "rd_div_lo"},
            '{1'b1, 3'd3, 9'h1FF, 9'h000, "wr_div_hi"},
            '{1'b0, 3'd3, 9'h000, 9'h07F, "rd_div_hi_7bit"},
            '{1'b0, 3'd2, 9'h000, 9'h0AA, "div_lo_kept"},
            '{1'b1, 3'd1, 9'h004, 9'h000, "wr_loopback_on"},
            '{1'b0, 3'd1, 9'h000, 9'h044, "rd_loopback_on"},
            '{1'b1, 3'd1, 9'h000, 9'h000, "wr_loopback_off"},
            '{1'b0, 3'd1, 9'h000, 9'h004, "rd_loopback_off"},
            '{1'b1, 3'd6, 9'h1FF, 9'h000, "wr_port6"},
            '{1'b0, 3'd6, 9'h000, 9'h000, "rd_port6"},
            '{1'b0, 3'd2, 9'h000, 9'h0AA, "div_after_port6"}
        };
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) io_write(vecs[i].port, vecs[i].data);
            else begin
                io_read(vecs[i].port, 1'b0, v);
                check(vecs[i].name, {7'd0, v}, {7'd0, vecs[i].exp});
            end
        end

        // ---------------------------------------------------- TX timing, div=3
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'h55, 1'b0};
            set_div(16'd3);
            io_write(3'd0, 9'h055);              // edge E
            for (int i = 0; i < 40; i++) begin
                tick();                          // after edge E+1+i
                check("tx55_bit", {15'd0, txd}, {15'd0, fr[i / 4]});
                if (i == 0) begin
                    peek(3'd1, v);
                    check("tx_busy_E1", {15'd0, v[2]}, 16'd0);
                end
            end
            peek(3'd1, v);
            check("tx_busy_E40", {15'd0, v[2]}, 16'd0);
            tick();
            peek(3'd1, v);
            check("tx_idle_E41", {15'd0, v[2]}, 16'd1);
            check("tx_idle_txd", {15'd0, txd}, 16'd1);
        end

        // ------------------------------------- randomized loopback frames
        io_write(3'd1, 9'h004);
        for (int k = 0; k < 12; k++) begin
            logic [7:0]  b;
            logic [15:0] d;
            logic [9:0]  got;
            int          p;
            b = (k == 0) ? 8'hA3 : 8'($urandom);
            d = (k == 0) ? 16'd3 : 16'($urandom_range(0, 9));
            p = ((d < 16'd3) ? 3 : int'(d)) + 1;
            set_div(d);
            io_write(3'd0, {1'b0, b});           // edge E
            got = '0;
            for (int c = 1; c <= 10 * p; c++) begin
                tick();
                if ((c - 1) % p == p / 2) got[(c - 1) / p] = txd;
            end
            check("lb_tx_frame", {6'd0, got}, {6'd0, 1'b1, b, 1'b0});
            repeat (p + 4) tick();
            peek(3'd0, v);
            check("lb_rx_data", {7'd0, v}, {7'd0, 1'b1, b});
            peek(3'd1, v);
            check("lb_rx_nonempty", {15'd0, v[0]}, 16'd1);
            io_read(3'd0, 1'b1, v);
            peek(3'd0, v);
            check("lb_rx_after_pop", {7'd0, v}, 16'd0);
            peek(3'd1, v);
            check("lb_status_after_pop", {7'd0, v}, 16'h044);
        end
        io_write(3'd1, 9'h000);

        // ------------------------------------- RX overrun, external rxd, div=7
        set_div(16'd7);
        q.delete();
        for (int f = 0; f < 9; f++) begin
            logic [7:0] b;
            b = 8'($urandom);
            q.push_back(b);
            send_frame(b, 1'b1, 8);
            repeat (8) tick();
        end
        repeat (20) tick();
        io_read(3'd1, 1'b1, v);
        check("ovr_status_preclear", {7'd0, v}, 16'h00D);
        peek(3'd1, v);
        check("ovr_status_cleared", {7'd0, v}, 16'h005);
        for (int i = 0; i < DEPTH; i++) begin
            io_read(3'd0, 1'b1, v);
            check("ovr_fifo_order", {7'd0, v}, {7'd0, 1'b1, q[i]});
        end
        peek(3'd0, v);
        check("ovr_fifo_drained", {7'd0, v}, 16'd0);
        peek(3'd1, v);
        check("ovr_status_drained", {7'd0, v}, 16'h004);

        // ------------------------------------- framing error
        send_frame(8'h3C, 1'b0, 8);
        repeat (16) tick();
        peek(3'd1, v);
        check("ferr_status", {7'd0, v}, 16'h014);
        peek(3'd0, v);
        check("ferr_fifo_empty", {7'd0, v}, 16'd0);
        io_read(3'd1, 1'b1, v);
        peek(3'd1, v);
        check("ferr_cleared", {7'd0, v}, 16'h004);

        // ------------------------------------- glitch rejection, div=63
        set_div(16'd63);
        rxd = 1'b0;
        repeat (20) tick();
        rxd = 1'b1;
        repeat (100) tick();
        peek(3'd1, v);
        check("glitch_status", {7'd0, v}, 16'h004);
        peek(3'd0, v);
        check("glitch_fifo", {7'd0, v}, 16'd0);
        begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, 1'b1, 64);
            repeat (64) tick();
            io_read(3'd0, 1'b1, v);
            check("post_glitch_frame", {7'd0, v}, {7'd0, 1'b1, b});
        end

        // ------------------------------------- TX overflow and flush, div=433
        set_div(16'd433);
        for (int w = 0; w < 10; w++) begin
            io_write(3'd0, 9'(w + 16));
            if (w == 8) begin
                peek(3'd1, v);
                check("txfull_after_9", {14'd0, v[5], v[1]}, 16'd1);
            end
            if (w == 9) begin
                peek(3'd1, v);
                check("txovf_after_10", {14'd0, v[5], v[1]}, 16'd3);
            end
        end
        io_write(3'd1, 9'h002);
        peek(3'd1, v);
        check("txflush_status", {7'd0, v}, 16'h020);
        wait_tx_idle(5000, "txflush_frame_done");
        repeat (20) tick();
        peek(3'd1, v);
        check("txflush_no_more", {7'd0, v}, 16'h024);
        check("txflush_txd_high", {15'd0, txd}, 16'd1);
        io_read(3'd1, 1'b1, v);
        peek(3'd1, v);
        check("txovf_cleared", {7'd0, v}, 16'h004);

        // ------------------------------------- reset mid-frame
        set_div(16'd3);
        io_write(3'd0, 9'h000);
        repeat (6) tick();
        check("midframe_txd_low", {15'd0, txd}, 16'd0);
        reset = 1'b1;
        tick();
        check("reset_txd_high", {15'd0, txd}, 16'd1);
        reset = 1'b0;
        peek(3'd1, v);
        check("reset_status", {7'd0, v}, 16'h004);
        peek(3'd2, v);
        check("reset_div_lo", {7'd0, v}, 16'h1B1);
        repeat (50) tick();
        check("reset_txd_stays", {15'd0, txd}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
